// File: rtl/polygon_vertex_loader.sv
// Double-buffered polygon vertex store. Vertices stream into a shadow bank and
// are swapped into the active bank on the last pixel of the frame after a commit.
module polygon_vertex_loader #(
    parameter int PIXEL_WIDTH      = 1280,
    parameter int PIXEL_HEIGHT     = 720,
    parameter int MAX_NUM_VERTICES = 32
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic [$clog2(PIXEL_WIDTH)-1:0]        hcount_in,
    input  logic [$clog2(PIXEL_HEIGHT)-1:0]       vcount_in,
    input  logic                                  start_in,
    input  logic                                  vertex_valid_in,
    input  logic signed [31:0]                    vertex_x_in,
    input  logic signed [31:0]                    vertex_y_in,
    output logic                                  vertex_ready_out,
    input  logic                                  commit_in,
    output logic signed [31:0]                    xs_out [MAX_NUM_VERTICES],
    output logic signed [31:0]                    ys_out [MAX_NUM_VERTICES],
    output logic [$clog2(MAX_NUM_VERTICES+1)-1:0] num_points_out,
    output logic                                  busy_out,
    output logic                                  swap_out,
    output logic                                  reject_out,
    output logic                                  overflow_out
);
    localparam int CW = $clog2(MAX_NUM_VERTICES+1);
    localparam int IW = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;
    localparam int HW = $clog2(PIXEL_WIDTH);
    localparam int VW = $clog2(PIXEL_HEIGHT);

    typedef enum logic [1:0] {IDLE, LOAD, PENDING} state_t;

    state_t            state;
    logic [CW-1:0]     wr_count;
    logic signed [31:0] shadow_x [MAX_NUM_VERTICES];
    logic signed [31:0] shadow_y [MAX_NUM_VERTICES];

    logic          frame_end;
    logic          accept;
    logic [CW-1:0] eff_count;

    assign frame_end = (hcount_in == HW'(PIXEL_WIDTH-1)) && (vcount_in == VW'(PIXEL_HEIGHT-1));

    // Ready depends only on registered state so there is no valid->ready path.
    assign vertex_ready_out = (state == LOAD) && (wr_count < CW'(MAX_NUM_VERTICES));
    assign busy_out         = (state != IDLE);
    assign accept           = vertex_valid_in && vertex_ready_out && !start_in;
    assign eff_count        = wr_count + CW'(accept);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            wr_count       <= '0;
            num_points_out <= '0;
            swap_out       <= 1'b0;
            reject_out     <= 1'b0;
            overflow_out   <= 1'b0;
            for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                xs_out[i]   <= '0;
                ys_out[i]   <= '0;
                shadow_x[i] <= '0;
                shadow_y[i] <= '0;
            end
        end else begin
            swap_out   <= 1'b0;
            reject_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        state        <= LOAD;
                        wr_count     <= '0;
                        overflow_out <= 1'b0;
                    end
                end
                LOAD: begin
                    if (start_in) begin
                        wr_count     <= '0;
                        overflow_out <= 1'b0;
                    end else begin
                        if (accept) begin
                            shadow_x[wr_count[IW-1:0]] <= vertex_x_in;
                            shadow_y[wr_count[IW-1:0]] <= vertex_y_in;
                            wr_count <= eff_count;
                        end else if (vertex_valid_in) begin
                            overflow_out <= 1'b1;
                        end
                        if (commit_in) begin
                            if (eff_count >= CW'(3)) begin
                                state <= PENDING;
                            end else begin
                                state      <= IDLE;
                                reject_out <= 1'b1;
                            end
                        end
                    end
                end
                PENDING: begin
                    if (frame_end) begin
                        for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                            xs_out[i] <= shadow_x[i];
                            ys_out[i] <= shadow_y[i];
                        end
                        num_points_out <= wr_count;
                        swap_out       <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_polygon_vertex_loader.sv
// Directed bench for polygon_vertex_loader with hand-computed expectations.
module tb_polygon_vertex_loader;
    localparam int NV = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [10:0]        hcount = '0;
    logic [9:0]         vcount = '0;
    logic               start = 1'b0;
    logic               valid = 1'b0;
    logic signed [31:0] vx = '0;
    logic signed [31:0] vy = '0;
    logic               ready;
    logic               commit = 1'b0;
    logic signed [31:0] xs [NV];
    logic signed [31:0] ys [NV];
    logic [5:0]         num_points;
    logic               busy, swap, reject, overflow;

    int cmp_count = 0;
    int err_count = 0;

    polygon_vertex_loader dut (
        .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
        .start_in(start), .vertex_valid_in(valid), .vertex_x_in(vx), .vertex_y_in(vy),
        .vertex_ready_out(ready), .commit_in(commit), .xs_out(xs), .ys_out(ys),
        .num_points_out(num_points), .busy_out(busy), .swap_out(swap),
        .reject_out(reject), .overflow_out(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_count++;
        if (obs !== exp) begin
            err_count++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs set before tick are sampled by its edge; outputs are read 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic push(input int x, input int y);
        valid = 1'b1; vx = x; vy = y; tick(); valid = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1; tick(); commit = 1'b0;
    endtask

    task automatic frame_end();
        hcount = 11'd1279; vcount = 10'd719; tick(); hcount = '0; vcount = '0;
    endtask

    initial begin
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        check("rst_num", 32'(num_points), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_xs0", xs[0], 0);

        // Reset mid-LOAD
        do_start(); push(5, 6);
        check("load_busy", 32'(busy), 1);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        check("midrst_ready", 32'(ready), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ovf", 32'(overflow), 0);
        check("midrst_swap", 32'(swap | reject), 0);

        // Frame end in IDLE does nothing
        frame_end();
        check("idle_fe_swap", 32'(swap), 0);

        // Normal load
        do_start();
        check("norm_ready", 32'(ready), 1);
        push(100, 100); push(200, 100); push(150, 200);
        do_commit();
        check("norm_pend_busy", 32'(busy), 1);
        check("norm_pend_ready", 32'(ready), 0);
        tick(); tick();
        check("norm_prefe_num", 32'(num_points), 0);
        check("norm_prefe_xs0", xs[0], 0);
        frame_end();
        check("norm_swap", 32'(swap), 1);
        check("norm_busy", 32'(busy), 0);
        check("norm_num", 32'(num_points), 3);
        check("norm_xs0", xs[0], 100);
        check("norm_xs1", xs[1], 200);
        check("norm_xs2", xs[2], 150);
        check("norm_ys2", ys[2], 200);
        tick();
        check("norm_swap_once", 32'(swap), 0);

        // Short commit
        do_start(); push(1, 1); push(2, 2); do_commit();
        check("short_reject", 32'(reject), 1);
        check("short_busy", 32'(busy), 0);
        check("short_num", 32'(num_points), 3);
        tick();
        check("short_reject_once", 32'(reject), 0);
        check("short_xs0", xs[0], 100);

        // Overflow: 33 continuous offers
        do_start();
        valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            vx = i; vy = -i; tick();
        end
        check("ovf_ready_low", 32'(ready), 0);
        check("ovf_not_yet", 32'(overflow), 0);
        vx = 999; vy = 999; tick(); valid = 1'b0;
        check("ovf_set", 32'(overflow), 1);
        do_commit();
        check("ovf_busy", 32'(busy), 1);
        frame_end();
        check("ovf_num", 32'(num_points), 32);
        check("ovf_xs31", xs[31], 31);
        check("ovf_ys31", ys[31], 32'(-31));
        check("ovf_xs5", xs[5], 5);

        // Commit with 3rd vertex
        do_start(); push(7, 70); push(8, 80);
        valid = 1'b1; vx = 9; vy = 90; commit = 1'b1; tick();
        valid = 1'b0; commit = 1'b0;
        check("cv_busy", 32'(busy), 1);
        check("cv_reject", 32'(reject), 0);
        frame_end();
        check("cv_num", 32'(num_points), 3);
        check("cv_xs2", xs[2], 9);
        check("cv_ys0", ys[0], 70);

        // Commit on frame-end cycle defers a full frame
        do_start(); push(11, 1); push(12, 2); push(13, 3);
        commit = 1'b1; hcount = 11'd1279; vcount = 10'd719; tick();
        commit = 1'b0; hcount = '0; vcount = '0;
        check("cfe_swap", 32'(swap), 0);
        check("cfe_busy", 32'(busy), 1);
        check("cfe_xs0_old", xs[0], 7);
        tick(); tick();
        frame_end();
        check("cfe_swap2", 32'(swap), 1);
        check("cfe_xs0", xs[0], 11);

        // Restart mid-LOAD, then PENDING lockout
        do_start();
        for (int i = 0; i < 5; i++) push(50 + i, 500 + i);
        start = 1'b1; valid = 1'b1; vx = 77; vy = 77; tick();
        start = 1'b0; valid = 1'b0;
        for (int i = 0; i < 4; i++) push(60 + i, 600 + i);
        do_commit();
        check("rs_busy", 32'(busy), 1);
        start = 1'b1; commit = 1'b1; valid = 1'b1; vx = 88; vy = 88; tick();
        start = 1'b0; commit = 1'b0; valid = 1'b0;
        check("pend_lock_busy", 32'(busy), 1);
        check("pend_lock_ready", 32'(ready), 0);
        frame_end();
        check("rs_num", 32'(num_points), 4);
        check("rs_xs0", xs[0], 60);
        check("rs_xs3", xs[3], 63);
        check("rs_ys3", ys[3], 603);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end
endmodule
